// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic {
    PRI_MEM = 1'b0,
    PRI_ALU = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_wb_out_reg.sv
// Registered register-file write stage: we/addr/data flops with $zero suppression.
module rf_wb_out_reg
  import rf_pkg::*;
#(
  parameter int unsigned AW = rf_pkg::ADDR_W,
  parameter int unsigned DW = rf_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_waddr_o,
  output logic [DW-1:0] rf_wdata_o
);

  logic          we_q,    we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // Writes to $zero are accepted upstream but never reach the register file;
  // addr/data keep showing the last real write.
  always_comb begin
    we_d    = wr_valid_i && (wr_addr_i != AW'(REG_ZERO));
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (we_d) begin
      waddr_d = wr_addr_i;
      wdata_d = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_we_o    = we_q;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Load-priority writeback arbiter with ALU starvation guard.
// Optional macro RF_WB_STATS_EN adds the conflict_cnt statistics output.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W       = rf_pkg::DATA_W,
  parameter int unsigned ADDR_W       = rf_pkg::ADDR_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
`ifdef RF_WB_STATS_EN
  output logic [15:0]       conflict_cnt,
`endif
  output logic [3:0]        starve_cnt
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("rf_wb_arbiter: STARVE_LIMIT must be in 1..15");
  end

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       alu_rdy, mem_rdy;
  logic       alu_hs, mem_hs, conflict;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign conflict = alu_valid && mem_valid;

  always_comb begin
    alu_rdy  = 1'b0;
    mem_rdy  = 1'b0;
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      PRI_MEM: begin
        mem_rdy = mem_valid;
        alu_rdy = alu_valid && !mem_valid;
        if (conflict) begin
          if (starve_q < LIMIT) starve_d = starve_q + 4'd1;
          if (starve_d == LIMIT) state_d = PRI_ALU;
        end
        if (alu_rdy) starve_d = '0;
      end
      PRI_ALU: begin
        alu_rdy  = alu_valid;
        mem_rdy  = mem_valid && !alu_valid;
        // Either the ALU is served now or it withdrew; both end the forced phase.
        state_d  = PRI_MEM;
        starve_d = '0;
      end
      default: begin
        state_d  = PRI_MEM;
        starve_d = '0;
      end
    endcase
  end

  // Ready is held low during reset so nothing handshakes into a cleared pipeline.
  assign alu_ready = rst_n && alu_rdy;
  assign mem_ready = rst_n && mem_rdy;
  assign alu_hs    = alu_valid && alu_ready;
  assign mem_hs    = mem_valid && mem_ready;

  assign wr_valid = alu_hs || mem_hs;
  assign wr_addr  = alu_hs ? alu_addr : mem_addr;
  assign wr_data  = alu_hs ? alu_data : mem_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PRI_MEM;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign starve_cnt = starve_q;

  rf_wb_out_reg #(
    .AW(ADDR_W),
    .DW(DATA_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid_i (wr_valid),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rf_we_o    (rf_we),
    .rf_waddr_o (rf_waddr),
    .rf_wdata_o (rf_wdata)
  );

`ifdef RF_WB_STATS_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
    end else if (conflict && conflict_q != '1) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule
